// File: rtl/prefetch_ar_arb.sv
// Read-address arbiter between demand (NVDLA) and prefetch AR channels toward DDR.
// Single holding register; starvation-forced prefetch; outstanding-prefetch throttle.
module prefetch_ar_arb #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned STARVE_WIDTH    = 4,
  parameter int unsigned LOG_MAX_OUT     = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       d_ar_valid,
  output logic                       d_ar_ready,
  input  logic [ADDR_BITS-1:0]       d_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
  input  logic [TID_WIDTH-1:0]       d_ar_id,
  input  logic                       p_ar_valid,
  output logic                       p_ar_ready,
  input  logic [ADDR_BITS-1:0]       p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
  input  logic [TID_WIDTH-1:0]       p_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  output logic                       m_ar_is_pref,
  input  logic                       pref_done,
  input  logic [STARVE_WIDTH-1:0]    starveLimit,
  input  logic [LOG_MAX_OUT:0]       maxPrefOut,
  output logic [LOG_MAX_OUT:0]       prefOutCnt
);

  localparam int unsigned CNT_W = LOG_MAX_OUT + 1;

  typedef enum logic [1:0] {
    ST_ARB_IDLE   = 2'd0,
    ST_ARB_DEMAND = 2'd1,
    ST_ARB_PREF   = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       arb_en_q;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic                       is_pref_q, is_pref_d;
  logic [STARVE_WIDTH-1:0]    starve_q, starve_d;
  logic [CNT_W-1:0]           pcnt_q, pcnt_d;

  logic pref_elig, pref_forced, can_grant, grant_d, grant_p, done_dec;

  assign pref_elig   = p_ar_valid & ~flush & (pcnt_q < maxPrefOut);
  assign pref_forced = pref_elig & (starveLimit != '0) & (starve_q >= starveLimit);
  // arb_en_q keeps the first edge after reset release grant-free
  assign can_grant   = (state_q == ST_ARB_IDLE) & en & arb_en_q & resetN;
  assign grant_p     = can_grant & (pref_forced | (~d_ar_valid & pref_elig));
  assign grant_d     = can_grant & ~pref_forced & d_ar_valid;
  assign done_dec    = pref_done & (pcnt_q != '0);

  assign d_ar_ready   = grant_d;
  assign p_ar_ready   = grant_p;
  assign m_ar_valid   = (state_q != ST_ARB_IDLE);
  assign m_ar_addr    = addr_q;
  assign m_ar_len     = len_q;
  assign m_ar_id      = id_q;
  assign m_ar_is_pref = is_pref_q;
  assign prefOutCnt   = pcnt_q;

  // Next-state, holding register and counter update
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    is_pref_d = is_pref_q;
    starve_d  = starve_q;
    pcnt_d    = pcnt_q;

    case (state_q)
      ST_ARB_IDLE: begin
        if (grant_d) begin
          state_d   = ST_ARB_DEMAND;
          addr_d    = d_ar_addr;
          len_d     = d_ar_len;
          id_d      = d_ar_id;
          is_pref_d = 1'b0;
        end else if (grant_p) begin
          state_d   = ST_ARB_PREF;
          addr_d    = p_ar_addr;
          len_d     = p_ar_len;
          id_d      = p_ar_id;
          is_pref_d = 1'b1;
        end
      end
      ST_ARB_DEMAND,
      ST_ARB_PREF: begin
        if (m_ar_ready) state_d = ST_ARB_IDLE;
      end
      default: state_d = ST_ARB_IDLE;
    endcase

    if (flush || grant_p) begin
      starve_d = '0;
    end else if (grant_d && pref_elig && (starve_q != '1)) begin
      starve_d = starve_q + STARVE_WIDTH'(1);
    end

    case ({grant_p, done_dec})
      2'b10:   pcnt_d = pcnt_q + CNT_W'(1);
      2'b01:   pcnt_d = pcnt_q - CNT_W'(1);
      default: pcnt_d = pcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_ARB_IDLE;
      arb_en_q  <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      is_pref_q <= 1'b0;
      starve_q  <= '0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      arb_en_q  <= 1'b1;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      is_pref_q <= is_pref_d;
      starve_q  <= starve_d;
      pcnt_q    <= pcnt_d;
    end
  end

endmodule
